// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pc_gen
//  Purpose  : RV32I front-end fetch-address generator. Holds the fetch PC and
//             issues it through a valid/ready request, with stall support,
//             branch/jump redirects (buffered while a request is outstanding),
//             misaligned-target trapping and an epoch tag for wrong-path drop.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             i_stall             - downstream back-pressure, withdraws request
//             i_fetch_ready       - fetch accepts the request this cycle
//             i_redirect_valid    - redirect taken this cycle
//             i_redirect_target   - redirect destination
//             o_pc / o_pc_valid   - fetch request address / valid
//             o_pc_epoch          - epoch tag travelling with o_pc
//             o_exc_valid         - one-cycle misaligned-target pulse
//             o_exc_tval          - offending target of the last exception
//  Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VEC   = 32'h0,
  parameter int               STEP        = 4,
  parameter int               IALIGN_BITS = 2,
  parameter logic [WIDTH-1:0] TRAP_VEC    = 32'h4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_fetch_ready,
  input  logic             i_redirect_valid,
  input  logic [WIDTH-1:0] i_redirect_target,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_pc_valid,
  output logic             o_pc_epoch,
  output logic             o_exc_valid,
  output logic [WIDTH-1:0] o_exc_tval
);

  localparam logic [WIDTH-1:0] c_step = WIDTH'(STEP);

  logic             r_run;
  logic [WIDTH-1:0] r_pc;
  logic             r_epoch;
  logic             r_pend_valid;
  logic [WIDTH-1:0] r_pend_target;
  logic             r_exc_valid;
  logic [WIDTH-1:0] r_exc_tval;

  logic             w_pc_valid;
  logic             w_acc;
  logic             w_outst;
  logic             w_tgt_ok;
  logic [WIDTH-1:0] w_eff;

  assign w_pc_valid = r_run & ~i_stall;
  assign w_acc      = w_pc_valid &  i_fetch_ready;
  // While a request is outstanding the presented pc/epoch must stay stable,
  // so redirects arriving then are parked in the pending buffer.
  assign w_outst    = w_pc_valid & ~i_fetch_ready;

  assign w_tgt_ok   = (i_redirect_target[IALIGN_BITS-1:0] == '0);
  assign w_eff      = w_tgt_ok ? i_redirect_target : TRAP_VEC;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run         <= 1'b0;
      r_pc          <= RESET_VEC;
      r_epoch       <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
      r_exc_valid   <= 1'b0;
      r_exc_tval    <= '0;
    end else begin
      r_run <= 1'b1;

      // Exception is raised as soon as the redirect is seen, even if pended.
      r_exc_valid <= i_redirect_valid & ~w_tgt_ok;
      if (i_redirect_valid && !w_tgt_ok) begin
        r_exc_tval <= i_redirect_target;
      end

      if (i_redirect_valid && !w_outst) begin
        r_pc         <= w_eff;
        r_epoch      <= ~r_epoch;
        r_pend_valid <= 1'b0;
      end else if (i_redirect_valid) begin
        // Latest redirect wins; earlier pending targets are overwritten.
        r_pend_valid  <= 1'b1;
        r_pend_target <= w_eff;
      end else if (w_acc && r_pend_valid) begin
        // The request accepted this cycle carries the old epoch and is dropped.
        r_pc         <= r_pend_target;
        r_epoch      <= ~r_epoch;
        r_pend_valid <= 1'b0;
      end else if (w_acc) begin
        r_pc <= r_pc + c_step;
      end
    end
  end

  assign o_pc        = r_pc;
  assign o_pc_valid  = w_pc_valid;
  assign o_pc_epoch  = r_epoch;
  assign o_exc_valid = r_exc_valid;
  assign o_exc_tval  = r_exc_tval;

endmodule
`default_nettype wire
